// File: rtl/video_timing_pkg.sv
// Shared timing defaults, colour width and beam-counter type for the 15 kHz raster generator.
package video_timing_pkg;

  localparam int COLOR_W = 6;
  localparam int CNT_W   = 10;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam int H_TOTAL_DEF         = 448;
  localparam int H_VIS_END_DEF       = 320;
  localparam int H_SYNC_START_DEF    = 344;
  localparam int H_SYNC_LEN_DEF      = 32;
  localparam int V_TOTAL_50_DEF      = 312;
  localparam int V_TOTAL_60_DEF      = 262;
  localparam int V_VIS_END_50_DEF    = 288;
  localparam int V_VIS_END_60_DEF    = 240;
  localparam int V_SYNC_START_50_DEF = 296;
  localparam int V_SYNC_START_60_DEF = 248;
  localparam int V_SYNC_LEN_DEF      = 4;
  localparam int INT_LEN_DEF         = 32;

  // Half-open window [lo, lo+len); callers guarantee lo+len fits in 10 bits.
  function automatic logic in_window(cnt_t v, cnt_t lo, cnt_t len);
    return (v >= lo) && (v < cnt_t'(lo + len));
  endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Beam position counters; the frame-rate mode is latched only on the frame-wrap cycle.
module video_timing_counter
  import video_timing_pkg::*;
#(
  parameter int H_TOTAL    = H_TOTAL_DEF,
  parameter int V_TOTAL_50 = V_TOTAL_50_DEF,
  parameter int V_TOTAL_60 = V_TOTAL_60_DEF
) (
  input  logic             clkvideo,
  input  logic             rst_n,
  input  logic             mode_60hz,
  output logic [CNT_W-1:0] hcnt,
  output logic [CNT_W-1:0] vcnt,
  output logic             mode_cur
);

  localparam cnt_t H_LAST    = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST_50 = cnt_t'(V_TOTAL_50 - 1);
  localparam cnt_t V_LAST_60 = cnt_t'(V_TOTAL_60 - 1);

  cnt_t v_last;
  assign v_last = mode_cur ? V_LAST_60 : V_LAST_50;

  always_ff @(posedge clkvideo or negedge rst_n) begin
    if (!rst_n) begin
      hcnt     <= '0;
      vcnt     <= '0;
      mode_cur <= 1'b0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      if (vcnt == v_last) begin
        vcnt     <= '0;
        mode_cur <= mode_60hz;
      end else begin
        vcnt <= vcnt + 1'b1;
      end
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

endmodule

// File: rtl/video_sync_gen.sv
// 15 kHz raster timing generator: window decode plus one output register stage so
// colour, syncs, blank and interrupt all lag the beam counters by exactly one clock.
module video_sync_gen
  import video_timing_pkg::*;
#(
  parameter int H_TOTAL         = H_TOTAL_DEF,
  parameter int H_VIS_END       = H_VIS_END_DEF,
  parameter int H_SYNC_START    = H_SYNC_START_DEF,
  parameter int H_SYNC_LEN      = H_SYNC_LEN_DEF,
  parameter int V_TOTAL_50      = V_TOTAL_50_DEF,
  parameter int V_TOTAL_60      = V_TOTAL_60_DEF,
  parameter int V_VIS_END_50    = V_VIS_END_50_DEF,
  parameter int V_VIS_END_60    = V_VIS_END_60_DEF,
  parameter int V_SYNC_START_50 = V_SYNC_START_50_DEF,
  parameter int V_SYNC_START_60 = V_SYNC_START_60_DEF,
  parameter int V_SYNC_LEN      = V_SYNC_LEN_DEF,
  parameter int INT_LEN         = INT_LEN_DEF
) (
  input  logic               clkvideo,
  input  logic               rst_n,
  input  logic               mode_60hz,
  input  logic [COLOR_W-1:0] ri,
  input  logic [COLOR_W-1:0] gi,
  input  logic [COLOR_W-1:0] bi,
  output logic [CNT_W-1:0]   hcnt,
  output logic [CNT_W-1:0]   vcnt,
  output logic [COLOR_W-1:0] ro,
  output logic [COLOR_W-1:0] go,
  output logic [COLOR_W-1:0] bo,
  output logic               hsync_ext_n,
  output logic               vsync_ext_n,
  output logic               csync_ext_n,
  output logic               blank,
  output logic               int_n
);

  localparam cnt_t H_VIS_END_C    = cnt_t'(H_VIS_END);
  localparam cnt_t H_SYNC_START_C = cnt_t'(H_SYNC_START);
  localparam cnt_t H_SYNC_LEN_C   = cnt_t'(H_SYNC_LEN);
  localparam cnt_t V_VIS_END_50_C = cnt_t'(V_VIS_END_50);
  localparam cnt_t V_VIS_END_60_C = cnt_t'(V_VIS_END_60);
  localparam cnt_t V_SS_50_C      = cnt_t'(V_SYNC_START_50);
  localparam cnt_t V_SS_60_C      = cnt_t'(V_SYNC_START_60);
  localparam cnt_t V_SYNC_LEN_C   = cnt_t'(V_SYNC_LEN);
  localparam cnt_t INT_LEN_C      = cnt_t'(INT_LEN);

  logic mode_cur;
  cnt_t v_vis_end;
  cnt_t v_sync_start;
  logic hs, vs, vis, irq;

  video_timing_counter #(
    .H_TOTAL    (H_TOTAL),
    .V_TOTAL_50 (V_TOTAL_50),
    .V_TOTAL_60 (V_TOTAL_60)
  ) u_counter (
    .clkvideo  (clkvideo),
    .rst_n     (rst_n),
    .mode_60hz (mode_60hz),
    .hcnt      (hcnt),
    .vcnt      (vcnt),
    .mode_cur  (mode_cur)
  );

  assign v_vis_end    = mode_cur ? V_VIS_END_60_C : V_VIS_END_50_C;
  assign v_sync_start = mode_cur ? V_SS_60_C : V_SS_50_C;

  assign hs  = in_window(hcnt, H_SYNC_START_C, H_SYNC_LEN_C);
  assign vs  = in_window(vcnt, v_sync_start, V_SYNC_LEN_C);
  assign vis = (hcnt < H_VIS_END_C) && (vcnt < v_vis_end);
  assign irq = (vcnt == v_sync_start) && (hcnt < INT_LEN_C);

  // XOR gives inverted serrations: csync goes high during hs while inside vsync.
  always_ff @(posedge clkvideo or negedge rst_n) begin
    if (!rst_n) begin
      hsync_ext_n <= 1'b1;
      vsync_ext_n <= 1'b1;
      csync_ext_n <= 1'b1;
      blank       <= 1'b1;
      int_n       <= 1'b1;
      ro          <= '0;
      go          <= '0;
      bo          <= '0;
    end else begin
      hsync_ext_n <= ~hs;
      vsync_ext_n <= ~vs;
      csync_ext_n <= ~(hs ^ vs);
      blank       <= ~vis;
      int_n       <= ~irq;
      ro          <= vis ? ri : '0;
      go          <= vis ? gi : '0;
      bo          <= vis ? bi : '0;
    end
  end

endmodule

// File: tb/tb_video_sync_gen.sv
// Randomized bench for video_sync_gen: beam position is derived from elapsed clocks
// since frame start, and every output is compared against the timing rules each cycle.
module tb_video_sync_gen;
  import video_timing_pkg::*;

  localparam int HT    = 64;
  localparam int HVE   = 40;
  localparam int HSS   = 48;
  localparam int HSL   = 8;
  localparam int VT50  = 40;
  localparam int VT60  = 30;
  localparam int VVE50 = 32;
  localparam int VVE60 = 24;
  localparam int VSS50 = 34;
  localparam int VSS60 = 26;
  localparam int VSL   = 3;
  localparam int IL    = 6;

  logic               clkvideo = 1'b0;
  logic               rst_n;
  logic               mode_60hz;
  logic [COLOR_W-1:0] ri, gi, bi;
  logic [CNT_W-1:0]   hcnt, vcnt;
  logic [COLOR_W-1:0] ro, go, bo;
  logic               hsync_ext_n, vsync_ext_n, csync_ext_n, blank, int_n;

  video_sync_gen #(
    .H_TOTAL(HT), .H_VIS_END(HVE), .H_SYNC_START(HSS), .H_SYNC_LEN(HSL),
    .V_TOTAL_50(VT50), .V_TOTAL_60(VT60), .V_VIS_END_50(VVE50), .V_VIS_END_60(VVE60),
    .V_SYNC_START_50(VSS50), .V_SYNC_START_60(VSS60), .V_SYNC_LEN(VSL), .INT_LEN(IL)
  ) dut (
    .clkvideo(clkvideo), .rst_n(rst_n), .mode_60hz(mode_60hz),
    .ri(ri), .gi(gi), .bi(bi), .hcnt(hcnt), .vcnt(vcnt),
    .ro(ro), .go(go), .bo(bo),
    .hsync_ext_n(hsync_ext_n), .vsync_ext_n(vsync_ext_n), .csync_ext_n(csync_ext_n),
    .blank(blank), .int_n(int_n)
  );

  always #5 clkvideo = ~clkvideo;

  int tests  = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference state: frame position comes from clocks elapsed since the frame began.
  int   k, frame_start, cur_h, cur_v;
  bit   frame_mode, mode_last;
  int   prev_h, prev_v;
  bit   prev_mode;
  logic [17:0] prev_rgb;
  bit   mode_sel, rnd_rgb;

  int   hs_run, vs_run, int_run, blank_cnt, last_fall;
  bit   have_fall, fall_mode, vs_obs_prev;

  function automatic int frame_len(bit m);
    return HT * (m ? VT60 : VT50);
  endfunction
  function automatic int vss(bit m);
    return m ? VSS60 : VSS50;
  endfunction
  function automatic int vve(bit m);
    return m ? VVE60 : VVE50;
  endfunction

  task automatic drive_inputs();
    logic [17:0] c;
    c = rnd_rgb ? 18'($urandom) : 18'h3FFFF;
    {ri, gi, bi} = c;
    if (rnd_rgb && $urandom_range(0, 999) == 0) mode_sel = ~mode_sel;
    mode_60hz = mode_sel;
    prev_rgb  = c;
    mode_last = mode_sel;
  endtask

  task automatic init_model();
    k = 0; frame_start = 0; frame_mode = 0;
    cur_h = 0; cur_v = 0;
    prev_h = 0; prev_v = 0; prev_mode = 0;
    hs_run = 0; vs_run = 0; int_run = 0; blank_cnt = 0;
    have_fall = 0; vs_obs_prev = 1;
    drive_inputs();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_hcnt"}, 32'(hcnt), 0);
    check({tag, "_vcnt"}, 32'(vcnt), 0);
    check({tag, "_hs"}, 32'(hsync_ext_n), 1);
    check({tag, "_vs"}, 32'(vsync_ext_n), 1);
    check({tag, "_cs"}, 32'(csync_ext_n), 1);
    check({tag, "_int"}, 32'(int_n), 1);
    check({tag, "_blank"}, 32'(blank), 1);
    check({tag, "_rgb"}, 32'({ro, go, bo}), 0);
  endtask

  task automatic step();
    int p;
    bit hs, vs, vis, irq;
    @(posedge clkvideo);
    #1;
    k++;
    p = k - frame_start;
    if (p == frame_len(frame_mode)) begin
      frame_start = k;
      frame_mode  = mode_last;
      p = 0;
    end
    cur_h = p % HT;
    cur_v = p / HT;
    check("hcnt", 32'(hcnt), cur_h);
    check("vcnt", 32'(vcnt), cur_v);

    hs  = (prev_h >= HSS) && (prev_h < HSS + HSL);
    vs  = (prev_v >= vss(prev_mode)) && (prev_v < vss(prev_mode) + VSL);
    vis = (prev_h < HVE) && (prev_v < vve(prev_mode));
    irq = (prev_v == vss(prev_mode)) && (prev_h < IL);
    check("hsync_n", 32'(hsync_ext_n), 32'(!hs));
    check("vsync_n", 32'(vsync_ext_n), 32'(!vs));
    check("csync_n", 32'(csync_ext_n), 32'(!(hs ^ vs)));
    check("blank", 32'(blank), 32'(!vis));
    check("int_n", 32'(int_n), 32'(!irq));
    check("rgb", 32'({ro, go, bo}), vis ? 32'(prev_rgb) : 0);

    if (hsync_ext_n === 1'b0) hs_run++;
    else if (hs_run > 0) begin check("hs_len", hs_run, HSL); hs_run = 0; end
    if (int_n === 1'b0) int_run++;
    else if (int_run > 0) begin check("int_len", int_run, IL); int_run = 0; end
    if (vsync_ext_n === 1'b0) vs_run++;
    else if (vs_run > 0) begin check("vs_len", vs_run, VSL * HT); vs_run = 0; end
    if (vs_obs_prev === 1'b1 && vsync_ext_n === 1'b0) begin
      if (have_fall)
        check("vs_period", k - last_fall,
              frame_len(fall_mode) - vss(fall_mode) * HT + vss(prev_mode) * HT);
      have_fall = 1; last_fall = k; fall_mode = prev_mode;
    end
    vs_obs_prev = vsync_ext_n;
    if (blank === 1'b1) blank_cnt++;
    if (prev_h == HT - 1) begin
      check("blank_line", blank_cnt, (prev_v < vve(prev_mode)) ? HT - HVE : HT);
      blank_cnt = 0;
    end

    prev_h = cur_h; prev_v = cur_v; prev_mode = frame_mode;
    drive_inputs();
  endtask

  initial begin
    rst_n = 1'b0; mode_60hz = 1'b0; ri = '0; gi = '0; bi = '0;
    mode_sel = 0; rnd_rgb = 0;
    #12;
    check_reset("rst");
    @(posedge clkvideo);
    #2;
    rst_n = 1'b1;
    init_model();

    // Colour held at 3F; switch to 60 Hz at line 10 of the first (50 Hz) frame.
    repeat (10 * HT) step();
    mode_sel = 1;
    repeat ((VT50 - 10) * HT + 2 * VT60 * HT) step();

    rnd_rgb  = 1;
    mode_sel = 0;
    repeat (3 * VT50 * HT) step();
    repeat (4000) step();

    // Reset asserted mid-hsync must clear every output at once.
    for (int i = 0; i < HT && cur_h != HSS + 2; i++) step();
    check("find_hsync", cur_h, HSS + 2);
    check("pre_rst_hs", 32'(hsync_ext_n), 0);
    #2 rst_n = 1'b0;
    #1 check_reset("midrst");
    #2 rst_n = 1'b1;
    mode_sel = 0;
    init_model();
    repeat (3000) step();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/video_sync_gen.md
# video_sync_gen

15 kHz raster timing generator that sits directly upstream of the VGA scandoubler. It produces the native-rate RGB stream and the active-low hsync, vsync and composite-sync signals that the scandoubler consumes on its pixel-rate clock. It also exports beam counters so the pixel source can fetch data combinationally, plus a per-frame interrupt. It supports a 50 Hz or 60 Hz frame, selected at frame boundaries.

## Interface
Parameters:
- H_TOTAL, 448: clocks per line
- H_VIS_END, 320: first non-visible hcnt value
- H_SYNC_START, 344: hcnt value where hsync asserts
- H_SYNC_LEN, 32: hsync width in clocks
- V_TOTAL_50, 312: lines per frame in 50 Hz mode
- V_TOTAL_60, 262: lines per frame in 60 Hz mode
- V_VIS_END_50, 288: first non-visible line, 50 Hz
- V_VIS_END_60, 240: first non-visible line, 60 Hz
- V_SYNC_START_50, 296: vsync start line, 50 Hz
- V_SYNC_START_60, 248: vsync start line, 60 Hz
- V_SYNC_LEN, 4: vsync width in lines
- INT_LEN, 32: int_n width in clocks

Ports:
- clkvideo  in  1  pixel-rate clock (same net as the scandoubler's clkvideo)
- rst_n  in  1  asynchronous, active-low reset
- mode_60hz  in  1  frame-rate select; sampled only at frame wrap
- ri, gi, bi  in  6 each  pixel colour for the current (hcnt, vcnt), valid in the same cycle
- hcnt  out  10  current horizontal position, 0..H_TOTAL-1
- vcnt  out  10  current line, 0..V_TOTAL_cur-1
- ro, go, bo  out  6 each  registered colour; forced to 0 while blanked
- hsync_ext_n, vsync_ext_n, csync_ext_n  out  1 each  registered, active-low syncs
- blank  out  1  registered, active-high
- int_n  out  1  registered, active-low frame interrupt

## Operation
- hcnt increments every clock. At H_TOTAL-1 it wraps to 0 and vcnt increments.
- vcnt wraps to 0 at V_TOTAL_cur-1, coincident with the hcnt wrap.
- mode_cur register: loads mode_60hz only on the frame-wrap cycle (hcnt=H_TOTAL-1 and vcnt=V_TOTAL_cur-1).
  - Mid-frame changes of mode_60hz have no effect until that cycle.
  - V_TOTAL_cur, V_VIS_END_cur and V_SYNC_START_cur are selected by mode_cur.
- Combinational windows, all ranges half-open:
  - hs = hcnt in [H_SYNC_START, H_SYNC_START+H_SYNC_LEN)
  - vs = vcnt in [V_SYNC_START_cur, V_SYNC_START_cur+V_SYNC_LEN)
  - vis = (hcnt < H_VIS_END) and (vcnt < V_VIS_END_cur)
  - irq = (vcnt = V_SYNC_START_cur) and (hcnt < INT_LEN)
- Registered outputs:
  - hsync_ext_n = ~hs; vsync_ext_n = ~vs
  - csync_ext_n = ~(hs ^ vs), which gives inverted-serration composite sync
  - blank = ~vis; int_n = ~irq
  - RGB = vis ? input : 0
- Counters are internal state; hcnt/vcnt are driven straight from those registers.

## Timing
- Reset values:
  - hcnt = 0, vcnt = 0, mode_cur = 0 (50 Hz)
  - hsync_ext_n = 1, vsync_ext_n = 1, csync_ext_n = 1, int_n = 1
  - blank = 1, ro/go/bo = 0
- Latency: every registered output reflects the (hcnt, vcnt, ri/gi/bi) of the previous cycle.
  - Colour and syncs are therefore mutually aligned at the output.
  - The pixel source needs zero-latency lookup.
- Reset release: first registered output (cycle 1) corresponds to hcnt=0, vcnt=0, i.e. visible.
- Reset assertion mid-line: all state returns to reset values immediately (asynchronous); no partial sync pulse is stretched.
- Horizontal sync: the hsync low pulse is exactly H_SYNC_LEN clocks and occurs once per line, including lines inside vsync.
- Vertical sync: the vsync low pulse spans exactly V_SYNC_LEN×H_TOTAL clocks and starts at hcnt=0 of V_SYNC_START_cur.
- Composite sync inside vsync: csync_ext_n is high only during the hs window.
- Arithmetic: all comparisons are unsigned and 10-bit. Parameters must satisfy:
  - H_SYNC_START+H_SYNC_LEN ≤ H_TOTAL
  - V_SYNC_START+V_SYNC_LEN ≤ V_TOTAL, for each mode
  - All values ≤ 1023

## Structure
- Package video_timing_pkg holds:
  - the default timing constants (both modes)
  - the 6-bit colour width constant
  - a 10-bit counter type
- Sub-module video_timing_counter owns the hcnt/vcnt/mode_cur registers and the wrap logic.
- The top level adds the window decode and the output register stage.

## Test plan
- Reset, then run one 50 Hz frame:
  - 448×312 = 139776 clocks between vsync_ext_n falling edges
  - hsync_ext_n low exactly 32 clocks per line
- Hold ri/gi/bi = 6'h3F:
  - ro = 6'h3F for 320 clocks per visible line and 0 otherwise
  - blank high for 128 clocks per line, and for whole lines 288..311
- Toggle mode_60hz to 1 at line 100:
  - the current frame still ends at 312 lines
  - the next frame is 448×262 = 117376 clocks
  - vsync starts at line 248
- On line 296, check int_n low exactly 32 clocks starting one clock after hcnt=0; csync_ext_n high only during hcnt 344..375 (delayed 1 clock).
- Assert rst_n low at hcnt=350 (inside hsync): all outputs read their reset values immediately; after release, counting restarts from 0,0.
